tmds_word_aligner: RTL
======================

TMDS_WORD_ALIGNER -- requirements
Module: tmds_word_aligner

Interface
REQ-001 Parameter LOCK_COUNT, default 8: consecutive control-token words needed to declare lock.
REQ-002 Parameter SEARCH_WINDOW, default 4096: cycles searched per slip position before a bitslip is issued.
REQ-003 Parameter SETTLE_CYCLES, default 4: cycles ignored after each bitslip while the deserializer realigns.
REQ-004 Parameter LOSS_WINDOW, default 65536: cycles without a qualifying token run, while locked, before lock is dropped.
REQ-005 Port clk_1x_in, input, 1: pixel-rate clock; one clock only; all logic on its rising edge.
REQ-006 Port reset_in, input, 1: reset, synchronous and active-high.
REQ-007 Port deser_data_in, input, 10: raw word from the 1:10 deserializer.
REQ-008 Port bitslip, output, 1: single-cycle pulse to the deserializer to shift the word boundary by one bit.
REQ-009 Port aligned, output, 1: high while in LOCKED.
REQ-010 Port data_out, output, 10: deser_data_in registered once, passed to the channel decoder.
REQ-011 Port ctl_detect, output, 1: registered flag, high when the previous input word was a control token.
REQ-012 Port slip_count, output, 4: current slip position, 0..9.
REQ-013 Port wrap_error, output, 1: sticky flag, set when all 10 positions fail to lock.

Function
REQ-014 Control tokens SHALL be exactly 1101010100, 0010101011, 0101010100 and 1010101011; all other words are non-tokens.
REQ-015 data_out and ctl_detect SHALL have a fixed latency of 1 cycle from deser_data_in, in every state.
REQ-016 A run counter SHALL increment on each token word, clear on any non-token word, and saturate at LOCK_COUNT.
REQ-017 FSM states SHALL be SEARCH, SLIP, SETTLE and LOCKED.
REQ-018 SEARCH: a window counter SHALL increment every cycle; the run counter reaching LOCK_COUNT SHALL cause a transition to LOCKED.
REQ-019 SEARCH: the window counter reaching SEARCH_WINDOW-1 without lock SHALL cause a transition to SLIP.
REQ-020 If lock and window expiry occur in the same cycle, lock SHALL win.
REQ-021 SLIP SHALL last exactly one cycle, with bitslip=1 during it.
REQ-022 In SLIP, slip_count SHALL increment modulo 10; on wrap from 9 to 0, wrap_error SHALL be set.
REQ-023 SLIP SHALL always transition to SETTLE.
REQ-024 SETTLE SHALL last SETTLE_CYCLES cycles, with the run and window counters held at 0, then transition to SEARCH.
REQ-025 LOCKED: a loss counter SHALL increment every cycle and clear whenever the run counter reaches LOCK_COUNT.
REQ-026 LOCKED: the loss counter reaching LOSS_WINDOW-1 SHALL cause a transition to SEARCH, with aligned falling on the next cycle.
REQ-027 LOCKED: slip_count SHALL be held.
REQ-028 bitslip SHALL be high only in SLIP; two bitslip pulses SHALL be separated by at least SETTLE_CYCLES+1 cycles.
REQ-029 wrap_error SHALL be cleared only by reset; a later lock SHALL NOT clear it.
REQ-030 Counter widths SHALL be sized from their parameters (clog2); no counter SHALL overflow past its terminal value.

Reset
REQ-031 With reset_in high at a clock edge, the next state SHALL be SEARCH.
REQ-032 On that reset edge, all counters and slip_count SHALL be set to 0.
REQ-033 On that reset edge, bitslip, aligned, ctl_detect and wrap_error SHALL be set to 0, and data_out to 10'b0.
REQ-034 Reset asserted in any state, including mid-SLIP or mid-SETTLE, SHALL take effect on that edge with no pending bitslip pulse.

Verification
REQ-035 After reset, apply 8 consecutive words of 0010101011 -> aligned=1 on the cycle after the 8th word; bitslip never asserted; slip_count=0.
REQ-036 Apply the word 0000011111 continuously with defaults -> bitslip pulses at cycle 4096 after reset and then every 4101 cycles; slip_count steps 1..9, then 0; wrap_error=1 after the 10th pulse.
REQ-037 Apply 7 tokens, 1 non-token, then 7 tokens -> no lock; then an 8th consecutive token -> aligned=1.
REQ-038 Lock, then apply non-tokens for LOSS_WINDOW cycles -> aligned=0 and the window count restarts; a token run of 8 re-locks with slip_count unchanged.
REQ-039 Assert reset_in during the SLIP cycle -> bitslip=0 on the next cycle; all outputs at reset values; state SEARCH.
REQ-040 Apply random words -> data_out equals deser_data_in delayed exactly 1 cycle, in every state.

Source files
------------

// File: rtl/tmds_word_aligner.sv
// TMDS word aligner: finds the 10-bit word boundary from control-token runs
// and drives the deserializer bitslip until a stable lock is found.
module tmds_word_aligner #(
    parameter int LOCK_COUNT    = 8,
    parameter int SEARCH_WINDOW = 4096,
    parameter int SETTLE_CYCLES = 4,
    parameter int LOSS_WINDOW   = 65536
) (
    input  logic       clk_1x_in,
    input  logic       reset_in,
    input  logic [9:0] deser_data_in,
    output logic       bitslip,
    output logic       aligned,
    output logic [9:0] data_out,
    output logic       ctl_detect,
    output logic [3:0] slip_count,
    output logic       wrap_error
);

    localparam int RUN_W = $clog2(LOCK_COUNT + 1);
    localparam int WIN_W = (SEARCH_WINDOW > 2) ? $clog2(SEARCH_WINDOW) : 1;
    localparam int SET_W = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int LOS_W = (LOSS_WINDOW > 2) ? $clog2(LOSS_WINDOW) : 1;

    localparam logic [RUN_W-1:0] RUN_MAX   = RUN_W'(LOCK_COUNT);
    localparam logic [WIN_W-1:0] WIN_LAST  = WIN_W'(SEARCH_WINDOW - 1);
    localparam logic [SET_W-1:0] SET_LAST  = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [LOS_W-1:0] LOSS_LAST = LOS_W'(LOSS_WINDOW - 1);

    typedef enum logic [1:0] {
        SEARCH,
        SLIP,
        SETTLE,
        LOCKED
    } state_t;

    state_t           state_q, state_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic [WIN_W-1:0] window_q, window_d;
    logic [SET_W-1:0] settle_q, settle_d;
    logic [LOS_W-1:0] loss_q, loss_d;
    logic [3:0]       slip_q, slip_d;
    logic             wrap_q, wrap_d;
    logic             bitslip_q, bitslip_d;
    logic             aligned_q, aligned_d;
    logic [9:0]       data_q;
    logic             ctl_q;
    logic             tok;
    logic             run_hit;

    function automatic logic is_token(input logic [9:0] w);
        return (w == 10'b1101010100) || (w == 10'b0010101011) ||
               (w == 10'b0101010100) || (w == 10'b1010101011);
    endfunction

    always_comb begin
        tok      = is_token(deser_data_in);
        state_d  = state_q;
        window_d = '0;
        settle_d = '0;
        loss_d   = '0;
        slip_d   = slip_q;
        wrap_d   = wrap_q;
        if (!tok) begin
            run_d = '0;
        end else if (run_q == RUN_MAX) begin
            run_d = run_q;
        end else begin
            run_d = run_q + 1'b1;
        end
        run_hit = (run_d == RUN_MAX);

        unique case (state_q)
            SEARCH: begin
                if (run_hit) begin
                    state_d = LOCKED;
                end else if (window_q == WIN_LAST) begin
                    state_d = SLIP;
                end else begin
                    window_d = window_q + 1'b1;
                end
            end
            SLIP: begin
                state_d = SETTLE;
                slip_d  = (slip_q == 4'd9) ? 4'd0 : slip_q + 4'd1;
                wrap_d  = wrap_q | (slip_q == 4'd9);
            end
            SETTLE: begin
                run_d = '0;
                if (settle_q == SET_LAST) begin
                    state_d = SEARCH;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            LOCKED: begin
                if (run_hit) begin
                    loss_d = '0;
                end else if (loss_q == LOSS_LAST) begin
                    state_d = SEARCH;
                end else begin
                    loss_d = loss_q + 1'b1;
                end
            end
        endcase

        bitslip_d = (state_d == SLIP);
        aligned_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk_1x_in) begin
        if (reset_in) begin
            state_q   <= SEARCH;
            run_q     <= '0;
            window_q  <= '0;
            settle_q  <= '0;
            loss_q    <= '0;
            slip_q    <= '0;
            wrap_q    <= 1'b0;
            bitslip_q <= 1'b0;
            aligned_q <= 1'b0;
            data_q    <= '0;
            ctl_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            run_q     <= run_d;
            window_q  <= window_d;
            settle_q  <= settle_d;
            loss_q    <= loss_d;
            slip_q    <= slip_d;
            wrap_q    <= wrap_d;
            bitslip_q <= bitslip_d;
            aligned_q <= aligned_d;
            data_q    <= deser_data_in;
            ctl_q     <= tok;
        end
    end

    assign bitslip    = bitslip_q;
    assign aligned    = aligned_q;
    assign data_out   = data_q;
    assign ctl_detect = ctl_q;
    assign slip_count = slip_q;
    assign wrap_error = wrap_q;

endmodule
